// File: rtl/cp0_cause_ctrl.sv
// CP0 Cause register (Reg 13) with synchronised level/edge interrupt front-end and masked request.
// Optional macro CP0_CAUSE_EIC_EN builds the registered priority vector on int_vec.
module cp0_cause_ctrl #(
    parameter int unsigned NUM_HW_IRQ  = 6,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [5:0]  EDGE_MASK   = 6'b000000,
    parameter int unsigned TIMER_LINE  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_HW_IRQ-1:0] irq_in,
    input  logic [NUM_HW_IRQ-1:0] irq_clear,
    input  logic                  timer_irq,
    input  logic                  exc_valid,
    input  logic [4:0]            exc_code,
    input  logic                  exc_bd,
    input  logic [1:0]            exc_ce,
    input  logic                  mtc0_we,
    input  logic [31:0]           mtc0_wdata,
    input  logic [7:0]            status_im,
    input  logic                  status_ie,
    input  logic                  status_exl,
    input  logic                  status_erl,
    output logic [31:0]           causereg,
    output logic                  int_req,
    output logic [2:0]            int_vec
);

    logic [NUM_HW_IRQ-1:0] r_sync [SYNC_STAGES];
    logic [NUM_HW_IRQ-1:0] r_prev;
    logic [NUM_HW_IRQ-1:0] r_pend;
    logic [5:0]            r_ip_hw;
    logic [1:0]            r_ip_sw;
    logic                  r_bd;
    logic                  r_ti;
    logic [1:0]            r_ce;
    logic                  r_dc;
    logic                  r_iv;
    logic [4:0]            r_exc;
    logic                  r_int_req;

    logic [NUM_HW_IRQ-1:0] w_timer_vec;
    logic [NUM_HW_IRQ-1:0] w_line;
    logic [NUM_HW_IRQ-1:0] w_rise;
    logic [NUM_HW_IRQ-1:0] w_pend_nx;
    logic [5:0]            w_ip_nx;
    logic [7:0]            w_masked;
    logic                  w_unused;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++)
                r_sync[k] <= '0;
        end else begin
            r_sync[0] <= irq_in;
            for (int unsigned k = 1; k < SYNC_STAGES; k++)
                r_sync[k] <= r_sync[k-1];
        end
    end

    always_comb begin
        w_timer_vec             = '0;
        w_timer_vec[TIMER_LINE] = timer_irq;
    end

    assign w_line = r_sync[SYNC_STAGES-1] | w_timer_vec;
    assign w_rise = w_line & ~r_prev;

    // Edge lines: IP mirrors the next pending state, so a new edge beats a simultaneous clear.
    always_comb begin
        w_pend_nx = '0;
        w_ip_nx   = '0;
        for (int unsigned i = 0; i < NUM_HW_IRQ; i++) begin
            if (EDGE_MASK[i]) begin
                w_pend_nx[i] = (r_pend[i] & ~irq_clear[i]) | w_rise[i];
                w_ip_nx[i]   = w_pend_nx[i];
            end else begin
                w_ip_nx[i]   = w_line[i];
            end
        end
    end

    assign w_masked = {r_ip_hw, r_ip_sw} & status_im;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev    <= '0;
            r_pend    <= '0;
            r_ip_hw   <= '0;
            r_ip_sw   <= '0;
            r_bd      <= 1'b0;
            r_ti      <= 1'b0;
            r_ce      <= '0;
            r_dc      <= 1'b0;
            r_iv      <= 1'b0;
            r_exc     <= '0;
            r_int_req <= 1'b0;
        end else begin
            r_prev    <= w_line;
            r_pend    <= w_pend_nx;
            r_ip_hw   <= w_ip_nx;
            r_ti      <= timer_irq;
            r_int_req <= status_ie & ~status_exl & ~status_erl & (|w_masked);
            if (mtc0_we) begin
                r_ip_sw <= mtc0_wdata[9:8];
                r_iv    <= mtc0_wdata[23];
                r_dc    <= mtc0_wdata[27];
            end
            if (exc_valid) begin
                r_exc <= exc_code;
                r_ce  <= exc_ce;
                if (!status_exl)
                    r_bd <= exc_bd;
            end
        end
    end

`ifdef CP0_CAUSE_EIC_EN
    logic [2:0] w_vec;
    logic [2:0] r_int_vec;

    always_comb begin
        w_vec = '0;
        for (int unsigned i = 0; i < 8; i++)
            if (w_masked[i])
                w_vec = 3'(i);
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_int_vec <= '0;
        else
            r_int_vec <= w_vec;
    end

    assign int_vec = r_int_vec;
`else
    assign int_vec = 3'b000;
`endif

    assign causereg = {r_bd, r_ti, r_ce, r_dc, 3'b000, r_iv, 7'b0000000,
                       r_ip_hw, r_ip_sw, 1'b0, r_exc, 2'b00};
    assign int_req  = r_int_req;

    assign w_unused = ^{mtc0_wdata[31:28], mtc0_wdata[26:24], mtc0_wdata[22:10],
                        mtc0_wdata[7:0], irq_clear};

endmodule

// File: tb/tb_cp0_cause_ctrl.sv
// Directed self-checking bench for cp0_cause_ctrl (line 1 edge-triggered, all others level).
module tb_cp0_cause_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  irq_in;
    logic [5:0]  irq_clear;
    logic        timer_irq;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic [1:0]  exc_ce;
    logic        mtc0_we;
    logic [31:0] mtc0_wdata;
    logic [7:0]  status_im;
    logic        status_ie;
    logic        status_exl;
    logic        status_erl;
    logic [31:0] causereg;
    logic        int_req;
    logic [2:0]  int_vec;

    int errors = 0;
    int checks = 0;

`ifdef CP0_CAUSE_EIC_EN
    localparam bit EIC = 1'b1;
`else
    localparam bit EIC = 1'b0;
`endif

    cp0_cause_ctrl #(
        .NUM_HW_IRQ (6),
        .SYNC_STAGES(2),
        .EDGE_MASK  (6'b000010),
        .TIMER_LINE (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .irq_clear (irq_clear),
        .timer_irq (timer_irq),
        .exc_valid (exc_valid),
        .exc_code  (exc_code),
        .exc_bd    (exc_bd),
        .exc_ce    (exc_ce),
        .mtc0_we   (mtc0_we),
        .mtc0_wdata(mtc0_wdata),
        .status_im (status_im),
        .status_ie (status_ie),
        .status_exl(status_exl),
        .status_erl(status_erl),
        .causereg  (causereg),
        .int_req   (int_req),
        .int_vec   (int_vec)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; irq_in = '0; irq_clear = '0; timer_irq = 1'b0;
        exc_valid = 1'b0; exc_code = '0; exc_bd = 1'b0; exc_ce = '0;
        mtc0_we = 1'b0; mtc0_wdata = '0; status_im = '0;
        status_ie = 1'b0; status_exl = 1'b0; status_erl = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(5);
        chk("reset_cause", causereg, 32'h0);
        chk("reset_req", {31'b0, int_req}, 32'h0);
        chk("reset_vec", {29'b0, int_vec}, 32'h0);

        // Level line 0 latency
        status_im = 8'h04; status_ie = 1'b1;
        irq_in[0] = 1'b1;
        tick(2);
        chk("lvl_ip_e2", {31'b0, causereg[10]}, 32'h0);
        tick();
        chk("lvl_ip_e3", causereg, 32'h0000_0400);
        chk("lvl_req_e3", {31'b0, int_req}, 32'h0);
        tick();
        chk("lvl_req_e4", {31'b0, int_req}, 32'h1);
        chk("lvl_vec_e4", {29'b0, int_vec}, EIC ? 32'd2 : 32'd0);
        irq_in[0] = 1'b0;
        tick(2);
        chk("lvl_drop_hold", {31'b0, causereg[10]}, 32'h1);
        tick();
        chk("lvl_drop_ip", {31'b0, causereg[10]}, 32'h0);
        tick();
        chk("lvl_drop_req", {31'b0, int_req}, 32'h0);
        status_im = 8'h00;

        // irq_clear on a level line is ignored
        irq_in[0] = 1'b1;
        tick(3);
        irq_clear[0] = 1'b1;
        tick();
        irq_clear[0] = 1'b0;
        chk("lvl_clr_ignored", {31'b0, causereg[10]}, 32'h1);
        irq_in[0] = 1'b0;
        tick(3);
        chk("lvl_clr_drop", causereg, 32'h0);

        // Edge line 1: one-cycle pulse latches
        irq_in[1] = 1'b1;
        tick();
        irq_in[1] = 1'b0;
        tick(2);
        chk("edge_latch", causereg, 32'h0000_0800);
        tick(4);
        chk("edge_hold", causereg, 32'h0000_0800);
        irq_clear[1] = 1'b1;
        tick();
        irq_clear[1] = 1'b0;
        chk("edge_clear", causereg, 32'h0);

        // Clear coinciding with a new rising edge: set wins
        irq_in[1] = 1'b1;
        tick(2);
        irq_clear[1] = 1'b1;
        tick();
        irq_clear[1] = 1'b0;
        chk("edge_set_wins", {31'b0, causereg[11]}, 32'h1);
        irq_in[1] = 1'b0;
        tick(3);
        chk("edge_set_hold", {31'b0, causereg[11]}, 32'h1);
        irq_clear[1] = 1'b1;
        tick();
        irq_clear[1] = 1'b0;
        chk("edge_clear2", {31'b0, causereg[11]}, 32'h0);

        // Timer bypasses the synchroniser
        timer_irq = 1'b1;
        tick();
        chk("timer_on", causereg, 32'h4000_8000);
        timer_irq = 1'b0;
        tick();
        chk("timer_off", causereg, 32'h0);

        // Software write
        mtc0_we = 1'b1; mtc0_wdata = 32'hFFFF_FFFF;
        tick();
        mtc0_we = 1'b0;
        chk("mtc0_all", causereg, 32'h0880_0300);
        status_im = 8'h01; status_ie = 1'b1;
        tick();
        chk("sw_req", {31'b0, int_req}, 32'h1);
        chk("sw_vec", {29'b0, int_vec}, 32'd0);
        status_exl = 1'b1;
        tick();
        chk("exl_masks_req", {31'b0, int_req}, 32'h0);
        status_exl = 1'b0; status_erl = 1'b1;
        tick();
        chk("erl_masks_req", {31'b0, int_req}, 32'h0);
        status_erl = 1'b0; status_ie = 1'b0; status_im = 8'h00;
        mtc0_we = 1'b1; mtc0_wdata = 32'h0;
        tick();
        mtc0_we = 1'b0;
        chk("mtc0_zero", causereg, 32'h0);

        // Exception capture
        exc_valid = 1'b1; exc_code = 5'd8; exc_bd = 1'b1; exc_ce = 2'd1;
        tick();
        exc_valid = 1'b0;
        chk("exc_capture", causereg, 32'h9000_0020);
        status_exl = 1'b1;
        exc_valid = 1'b1; exc_code = 5'd12; exc_bd = 1'b0; exc_ce = 2'd2;
        tick();
        exc_valid = 1'b0; status_exl = 1'b0;
        chk("exc_bd_held", causereg, 32'hA000_0030);
        exc_valid = 1'b1; exc_code = 5'd3; exc_bd = 1'b0; exc_ce = 2'd0;
        mtc0_we = 1'b1; mtc0_wdata = 32'hFFFF_FFFF;
        tick();
        exc_valid = 1'b0; mtc0_we = 1'b0;
        chk("exc_and_mtc0", causereg, 32'h0880_030C);

        // Priority vector: timer (IP7) over line 2 (IP4)
        mtc0_we = 1'b1; mtc0_wdata = 32'h0;
        tick();
        mtc0_we = 1'b0;
        status_im = 8'hFF; status_ie = 1'b1;
        timer_irq = 1'b1; irq_in[2] = 1'b1;
        tick(3);
        chk("eic_ip", causereg[15:8], 32'h0000_0090);
        tick();
        chk("eic_req", {31'b0, int_req}, 32'h1);
        chk("eic_vec7", {29'b0, int_vec}, EIC ? 32'd7 : 32'd0);
        timer_irq = 1'b0;
        tick(2);
        chk("eic_vec4", {29'b0, int_vec}, EIC ? 32'd4 : 32'd0);
        chk("eic_req_keep", {31'b0, int_req}, 32'h1);

        // Reset mid-operation drops a pending edge
        irq_in[1] = 1'b1;
        tick();
        irq_in[1] = 1'b0;
        tick(2);
        chk("pre_rst_pend", {31'b0, causereg[11]}, 32'h1);
        irq_in = '0;
        reset = 1'b1;
        tick();
        chk("midrst_cause", causereg, 32'h0);
        chk("midrst_req", {31'b0, int_req}, 32'h0);
        chk("midrst_vec", {29'b0, int_vec}, 32'h0);
        reset = 1'b0;
        tick(4);
        chk("pend_lost", causereg, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cp0_cause_ctrl.md
Name: cp0_cause_ctrl

Overview:
- CP0 Cause register (Reg 13) with integrated interrupt front-end: per-line synchronisation, a per-line level/edge mode, and pending latches for edge lines.
- Adds software-writable fields (IP[1:0], IV, DC) and captures BD/CE/ExcCode on exceptions.
- Produces the registered masked interrupt request that the pipeline's exception unit consumes.
- Sits in the CP0 block, between the external IRQ pins/timer and the exception/EPC logic.

Parameters:
- NUM_HW_IRQ, 6, number of hardware IRQ lines mapped to IP[2+i]; legal range 1..6.
- SYNC_STAGES, 2, flop stages on each irq_in line; legal range 1..3.
- EDGE_MASK, 6'b000000, per-line mode; bit i=1 makes line i edge-triggered (rising), 0 makes it level.
- TIMER_LINE, 5, hardware line index that timer_irq is ORed into; must be < NUM_HW_IRQ.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- irq_in  in  NUM_HW_IRQ  asynchronous external interrupt lines
- irq_clear  in  NUM_HW_IRQ  one-cycle pulse; clears the pending latch of edge line i
- timer_irq  in  1  internal compare-timer pending (already in clk domain)
- exc_valid  in  1  exception commit pulse
- exc_code  in  5  ExcCode to capture
- exc_bd  in  1  faulting instruction is in a branch delay slot
- exc_ce  in  2  coprocessor number for CpU exceptions
- mtc0_we  in  1  software write to Cause
- mtc0_wdata  in  32  write data
- status_im  in  8  Status.IM[7:0]
- status_ie  in  1  Status.IE
- status_exl  in  1  Status.EXL
- status_erl  in  1  Status.ERL
- causereg  out  32  Cause register value
- int_req  out  1  registered interrupt request to the pipeline
- int_vec  out  3  highest-priority pending IP index (see Optional Feature)

Behaviour:
- Reset: causereg=0, int_req=0, int_vec=0; all sync flops, edge history and pending latches cleared.
- Layout:
  - BD[31], TI[30], CE[29:28], DC[27], IV[23].
  - IP[15:10] hardware, IP[9:8] software, ExcCode[6:2].
  - All other bits read 0. IP bits for lines >= NUM_HW_IRQ read 0.
- Synchroniser: irq_in[i] passes through SYNC_STAGES flops. The effective line is s[i] = synced irq_in[i], ORed with timer_irq when i==TIMER_LINE.
- Level line: IP[2+i] <= s[i] every cycle.
- Edge line:
  - pend[i] sets on s[i] & ~s_prev[i].
  - pend[i] clears on irq_clear[i].
  - Set and clear in the same cycle: set wins.
  - IP[2+i] <= pend[i] | (set this cycle).
  - irq_clear on a level line is ignored.
- Latency: a level irq_in rising before edge 1 is visible in causereg.IP at edge SYNC_STAGES+1 and in int_req at edge SYNC_STAGES+2. timer_irq bypasses sync and appears in IP/TI at the next edge.
- TI <= timer_irq every cycle.
- mtc0_we: writes IP[9:8], IV(23) and DC(27) from mtc0_wdata. All other bits are unaffected by software writes.
- exc_valid:
  - ExcCode <= exc_code and causereg[1:0] <= 0.
  - CE <= exc_ce.
  - BD <= exc_bd only when status_exl==0; otherwise BD is held.
- mtc0_we and exc_valid in the same cycle: both apply; their field sets are disjoint, so there is no conflict.
- int_req <= status_ie & ~status_exl & ~status_erl & |(causereg[15:8] & status_im), computed from the current registered IP. Dropping an enable deasserts int_req one cycle later.
- Reset asserted mid-operation: all state returns to reset values on that edge, and pending edges are lost.

Optional Feature:
- Macro: CP0_CAUSE_EIC_EN.
- With the macro: int_vec is registered in the same cycle as int_req and holds the index of the highest set bit of (IP & IM). Priority is 7 highest, 0 lowest. int_vec is 0 when nothing is enabled and pending.
- Without the macro: int_vec is tied to 3'b000 and no priority encoder is built.

Test Plan:
- Reset, then idle 5 cycles -> causereg=0x00000000, int_req=0, int_vec=0.
- Level line 0 (default params), IM=8'h04, IE=1, EXL=0; raise irq_in[0] before edge 1 -> IP[10]=1 at edge 3, int_req=1 at edge 4; drop irq_in[0] -> IP[10]=0 two-plus-one edges later.
- EDGE_MASK=6'b000010: pulse irq_in[1] for 1 cycle -> IP[11] stays 1 after the line drops; irq_clear[1] pulse -> IP[11]=0 next edge. irq_clear coinciding with a new edge -> IP[11] stays 1.
- mtc0_we with wdata=0xFFFFFFFF -> causereg=0x08800300 (DC, IV, IP[1:0] only). With IM=8'h01 and IE=1 -> int_req=1 one edge later.
- exc_valid with code=5'd8, bd=1, ce=2'd1, EXL=0 -> causereg[31]=1, [29:28]=01, [6:2]=8. Repeat with EXL=1 and bd=0 -> BD stays 1, ExcCode updates.
- CP0_CAUSE_EIC_EN defined, IM=8'hFF, IE=1, timer_irq=1 and irq_in[2] high -> int_vec=7 (timer on line 5 → IP7). Drop timer -> int_vec=4.
